// File: rtl/add_scheduler.sv
// Two-requester round-robin front end sharing one WIDTH-bit adder and one result register.
// Define ADD_SCHED_SAT_EN to saturate the sum to all ones on carry-out.
module add_sched_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);
    assign sum = {1'b0, x} + {1'b0, y};
endmodule

module add_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_x,
    input  logic [WIDTH-1:0] b_y,
    output logic             b_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_id,
    output logic [7:0]       op_count
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } operand_t;

    state_t           state, state_next;
    logic             last_grant;   // 0 = A, 1 = B
    logic             slot_free;
    logic             accept;
    operand_t         req_a, req_b, req_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] data_next;
    logic             carry_next;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (!accept && res_ready) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // outputs: grants are combinational, the requester that did not win last gets a tie
    always_comb begin
        res_valid = (state == FULL);
        slot_free = !res_valid || res_ready;
        a_ready   = !rst && slot_free && a_valid && (!b_valid || last_grant);
        b_ready   = !rst && slot_free && b_valid && (!a_valid || !last_grant);
    end

    assign accept  = a_ready || b_ready;
    assign req_a   = '{x: a_x, y: a_y};
    assign req_b   = '{x: b_x, y: b_y};
    assign req_sel = b_ready ? req_b : req_a;

    add_sched_adder #(.WIDTH(WIDTH)) u_adder (
        .x   (req_sel.x),
        .y   (req_sel.y),
        .sum (sum)
    );

    assign carry_next = sum[WIDTH];
`ifdef ADD_SCHED_SAT_EN
    assign data_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign data_next = sum[WIDTH-1:0];
`endif

    // result register and bookkeeping only move on an accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data   <= '0;
            res_carry  <= 1'b0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
            op_count   <= 8'd0;
        end else if (accept) begin
            res_data   <= data_next;
            res_carry  <= carry_next;
            res_id     <= b_ready;
            last_grant <= b_ready;
            op_count   <= op_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_add_scheduler.sv
// Scoreboard bench for add_scheduler: driver predicts grants and pushes expected results, monitor checks them.
module tb_add_scheduler;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, res_ready;
    logic [W-1:0] a_x, a_y, b_x, b_y;
    logic         a_ready, b_ready, res_valid, res_carry, res_id;
    logic [W-1:0] res_data;
    logic [7:0]   op_count;

    add_scheduler #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_ready(a_ready),
        .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_ready(b_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_id(res_id),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic         id;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       m_full;
    logic       m_last;
    logic [7:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic id);
        exp_t e;
        int   s;
        s    = int'(x) + int'(y);
        e.c  = (s >= (1 << W));
        e.d  = W'(s % (1 << W));
`ifdef ADD_SCHED_SAT_EN
        if (e.c) e.d = {W{1'b1}};
`endif
        e.id = id;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic av, input logic [W-1:0] ax, input logic [W-1:0] ay,
                        input logic bv, input logic [W-1:0] bx, input logic [W-1:0] by,
                        input logic rr);
        logic slot, ea, eb;
        a_valid = av; a_x = ax; a_y = ay;
        b_valid = bv; b_x = bx; b_y = by;
        res_ready = rr;
        @(negedge clk);
        slot = !m_full || rr;
        ea = !rst && slot && av && (!bv || m_last == 1'b1);
        eb = !rst && slot && bv && (!av || m_last == 1'b0);
        chk("a_ready", a_ready, ea);
        chk("b_ready", b_ready, eb);
        @(posedge clk);
        if (!rst) begin
            if (ea) begin
                sb.push_back(model_add(ax, ay, 1'b0));
                m_last = 1'b0;
                m_cnt  = m_cnt + 8'd1;
            end else if (eb) begin
                sb.push_back(model_add(bx, by, 1'b1));
                m_last = 1'b1;
                m_cnt  = m_cnt + 8'd1;
            end
            m_full = (ea || eb) ? 1'b1 : (rr ? 1'b0 : m_full);
        end
        #1;
    endtask

    // Pulse reset with both requesters valid; effects must be immediate.
    task automatic do_reset();
        a_valid = 1'b1; b_valid = 1'b1; res_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_carry", res_carry, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        sb.delete();
        m_full = 1'b0; m_last = 1'b1; m_cnt = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // Monitor: whenever a result is presented it must match the oldest expected entry.
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                chk("res_valid_unexpected", res_valid, 0);
            end else begin
                chk("res_data", res_data, sb[0].d);
                chk("res_carry", res_carry, sb[0].c);
                chk("res_id", res_id, sb[0].id);
                if (res_ready) void'(sb.pop_front());
            end
        end else begin
            chk("res_valid_missing", res_valid, (sb.size() != 0) ? 1 : 0);
        end
        chk("op_count", op_count, m_cnt);
    end

    initial begin
        rst = 1'b1;
        a_valid = 0; b_valid = 0; res_ready = 0;
        a_x = 0; a_y = 0; b_x = 0; b_y = 0;
        m_full = 1'b0; m_last = 1'b1; m_cnt = 8'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("init_res_valid", res_valid, 0);
        chk("init_op_count", op_count, 0);
        chk("init_a_ready", a_ready, 0);
        rst = 1'b0;

        // single A request
        step(1, 8'd20, 8'd22, 0, 0, 0, 1);
        chk("a_only_res_valid", res_valid, 1);
        chk("a_only_data", res_data, 42);
        chk("a_only_id", res_id, 0);
        chk("a_only_carry", res_carry, 0);
        chk("a_only_count", op_count, 1);

        // round-robin on sustained ties: A,B,A,B
        do_reset();
        for (int i = 0; i < 4; i++)
            step(1, W'($urandom), W'($urandom), 1, W'($urandom), W'($urandom), 1);
        chk("rr_count", op_count, 4);
        chk("rr_last_id", res_id, 1);

        // overflow from B
        step(0, 0, 0, 1, 8'd200, 8'd100, 1);
`ifdef ADD_SCHED_SAT_EN
        chk("wrap_data", res_data, 255);
`else
        chk("wrap_data", res_data, 44);
`endif
        chk("wrap_carry", res_carry, 1);
        chk("wrap_id", res_id, 1);

        // backpressure with both waiting, then drain + accept together
        for (int i = 0; i < 3; i++)
            step(1, 8'd1, 8'd2, 1, 8'd3, 8'd4, 0);
        chk("bp_held_data", res_data, model_add(8'd200, 8'd100, 1'b1).d);
        step(1, 8'd1, 8'd2, 1, 8'd3, 8'd4, 1);
        chk("bp_new_id", res_id, 0);
        chk("bp_new_data", res_data, 3);

        // reset while a result is pending; first tie afterwards goes to A
        do_reset();
        step(1, 8'd5, 8'd6, 1, 8'd7, 8'd8, 1);
        chk("post_rst_id", res_id, 0);
        chk("post_rst_count", op_count, 1);

        // op_count wrap
        do_reset();
        for (int i = 0; i < 256; i++)
            step(1, W'($urandom), W'($urandom), 0, 0, 0, 1);
        chk("count_wrap", op_count, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++)
            step(($urandom % 3) != 0, W'($urandom), W'($urandom),
                 ($urandom % 3) != 0, W'($urandom), W'($urandom),
                 ($urandom % 4) != 0);

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
        chk("drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
